// File: rtl/countdown_timer_if.sv
// Button and display signals of the countdown timer, grouped for the display/control side
// (master) and the timer itself (slave).
interface countdown_timer_if;
    logic       TIMER_RUN;
    logic       SW_F1;
    logic       SW_F2;
    logic       SW_F3;
    logic [3:0] HOUR;
    logic [2:0] MINHIGH;
    logic [3:0] MINLOW;
    logic [2:0] SECHIGH;
    logic [3:0] SECLOW;
    logic [1:0] SEL;
    logic       RUNNING;
    logic       ALARM;

    modport master (
        output TIMER_RUN, SW_F1, SW_F2, SW_F3,
        input  HOUR, MINHIGH, MINLOW, SECHIGH, SECLOW, SEL, RUNNING, ALARM
    );

    modport slave (
        input  TIMER_RUN, SW_F1, SW_F2, SW_F3,
        output HOUR, MINHIGH, MINLOW, SECHIGH, SECLOW, SEL, RUNNING, ALARM
    );
endinterface

// File: rtl/countdown_timer.sv
// BCD h:mm:ss countdown timer: edit a preset, count it down once per second, then raise an
// alarm that clears on timeout or on any button edge.
module countdown_timer #(
    parameter int unsigned CLKS_PER_SEC = 1000,
    parameter int unsigned ALARM_SECS   = 10
) (
    input  logic CLK,
    input  logic RST,
    countdown_timer_if.slave tmr
);
    typedef struct packed {
        logic [3:0] hr;
        logic [2:0] min_hi;
        logic [3:0] min_lo;
        logic [2:0] sec_hi;
        logic [3:0] sec_lo;
    } bcd_time_t;

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    localparam int unsigned PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam int unsigned AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SEC - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);

    state_e    state_q, state_d;
    bcd_time_t preset_q, preset_d;
    bcd_time_t work_q, work_d;
    bcd_time_t work_dec;
    logic [PW-1:0] presc_q, presc_d, presc_next;
    logic [AW-1:0] acnt_q, acnt_d;
    logic [1:0]    sel_q, sel_d;
    logic f1_q, f2_q, f3_q;
    logic edge_f1, edge_f2, edge_f3, edge_any, presc_wrap;

    // Fields wrap independently: editing never carries into a neighbouring field.
    function automatic bcd_time_t inc_field(input bcd_time_t t, input logic [1:0] sel);
        bcd_time_t r;
        r = t;
        case (sel)
            2'd0: r.hr = (t.hr == 4'd9) ? 4'd0 : t.hr + 4'd1;
            2'd1: begin
                if (t.min_lo == 4'd9) begin
                    r.min_lo = 4'd0;
                    r.min_hi = (t.min_hi == 3'd5) ? 3'd0 : t.min_hi + 3'd1;
                end else begin
                    r.min_lo = t.min_lo + 4'd1;
                end
            end
            2'd2: begin
                if (t.sec_lo == 4'd9) begin
                    r.sec_lo = 4'd0;
                    r.sec_hi = (t.sec_hi == 3'd5) ? 3'd0 : t.sec_hi + 3'd1;
                end else begin
                    r.sec_lo = t.sec_lo + 4'd1;
                end
            end
            default: r = t;
        endcase
        return r;
    endfunction

    function automatic bcd_time_t dec_second(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.sec_lo != 4'd0) begin
            r.sec_lo = t.sec_lo - 4'd1;
        end else begin
            r.sec_lo = 4'd9;
            if (t.sec_hi != 3'd0) begin
                r.sec_hi = t.sec_hi - 3'd1;
            end else begin
                r.sec_hi = 3'd5;
                if (t.min_lo != 4'd0) begin
                    r.min_lo = t.min_lo - 4'd1;
                end else begin
                    r.min_lo = 4'd9;
                    if (t.min_hi != 3'd0) begin
                        r.min_hi = t.min_hi - 3'd1;
                    end else begin
                        r.min_hi = 3'd5;
                        r.hr     = t.hr - 4'd1;
                    end
                end
            end
        end
        return r;
    endfunction

    // Masking lower-priority edges leaves at most one honored edge per cycle.
    assign edge_f1  = tmr.TIMER_RUN & tmr.SW_F1 & ~f1_q;
    assign edge_f2  = tmr.TIMER_RUN & tmr.SW_F2 & ~f2_q & ~edge_f1;
    assign edge_f3  = tmr.TIMER_RUN & tmr.SW_F3 & ~f3_q & ~edge_f1 & ~edge_f2;
    assign edge_any = edge_f1 | edge_f2 | edge_f3;

    always_comb begin
        state_d    = state_q;
        preset_d   = preset_q;
        work_d     = work_q;
        presc_d    = presc_q;
        acnt_d     = acnt_q;
        sel_d      = sel_q;
        presc_wrap = (presc_q == PRESC_LAST);
        presc_next = presc_wrap ? '0 : presc_q + PW'(1);
        work_dec   = dec_second(work_q);
        case (state_q)
            StIdle: begin
                if (edge_f2) begin
                    sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
                end else if (edge_f3) begin
                    preset_d = inc_field(preset_q, sel_q);
                end else if (edge_f1 && preset_q != '0) begin
                    state_d = StRun;
                    presc_d = '0;
                end
                work_d = preset_d;
            end
            StRun: begin
                presc_d = presc_next;
                if (presc_wrap) work_d = work_dec;
                if (presc_wrap && work_dec == '0) begin
                    state_d = StDone;
                    acnt_d  = '0;
                end else if (edge_f1) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (edge_f1) begin
                    state_d = StRun;
                end else if (edge_f2) begin
                    state_d = StIdle;
                    work_d  = preset_q;
                end
            end
            StDone: begin
                presc_d = presc_next;
                if (presc_wrap) acnt_d = acnt_q + AW'(1);
                if ((presc_wrap && acnt_q == ALARM_LAST) || edge_any) begin
                    state_d = StIdle;
                    work_d  = preset_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            preset_q <= '0;
            work_q   <= '0;
            presc_q  <= '0;
            acnt_q   <= '0;
            sel_q    <= '0;
            f1_q     <= 1'b0;
            f2_q     <= 1'b0;
            f3_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            preset_q <= preset_d;
            work_q   <= work_d;
            presc_q  <= presc_d;
            acnt_q   <= acnt_d;
            sel_q    <= sel_d;
            f1_q     <= tmr.SW_F1;
            f2_q     <= tmr.SW_F2;
            f3_q     <= tmr.SW_F3;
        end
    end

    assign tmr.HOUR    = work_q.hr;
    assign tmr.MINHIGH = work_q.min_hi;
    assign tmr.MINLOW  = work_q.min_lo;
    assign tmr.SECHIGH = work_q.sec_hi;
    assign tmr.SECLOW  = work_q.sec_lo;
    assign tmr.SEL     = sel_q;
    assign tmr.RUNNING = (state_q == StRun);
    assign tmr.ALARM   = (state_q == StDone);
endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: a seconds-based model checked every cycle, plus hand-computed
// display values at the interesting points.
module tb_countdown_timer;
    localparam int unsigned CPS = 4;
    localparam int unsigned AS  = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    countdown_timer_if tmr ();

    countdown_timer #(.CLKS_PER_SEC(CPS), .ALARM_SECS(AS)) dut (
        .CLK (CLK),
        .RST (RST),
        .tmr (tmr)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model state: times held as plain seconds.
    int m_mode = M_IDLE, m_preset = 0, m_work = 0, m_presc = 0, m_acnt = 0, m_sel = 0;
    bit m_p1 = 1'b0, m_p2 = 1'b0, m_p3 = 1'b0;

    function automatic logic [17:0] disp(input int secs);
        int h, m, s;
        h = secs / 3600;
        m = (secs / 60) % 60;
        s = secs % 60;
        return {4'(h), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int hms(input int h, input int m, input int s);
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic int bump(input int t, input int sel);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        if (sel == 0) h = (h + 1) % 10;
        else if (sel == 1) m = (m + 1) % 60;
        else s = (s + 1) % 60;
        return hms(h, m, s);
    endfunction

    task automatic model_step();
        bit e1, e2, e3, wrap;
        e1 = tmr.TIMER_RUN && tmr.SW_F1 && !m_p1;
        e2 = tmr.TIMER_RUN && tmr.SW_F2 && !m_p2 && !e1;
        e3 = tmr.TIMER_RUN && tmr.SW_F3 && !m_p3 && !e1 && !e2;
        m_p1 = tmr.SW_F1;
        m_p2 = tmr.SW_F2;
        m_p3 = tmr.SW_F3;
        if (RST) begin
            m_mode = M_IDLE; m_preset = 0; m_work = 0; m_presc = 0; m_acnt = 0; m_sel = 0;
            m_p1 = 0; m_p2 = 0; m_p3 = 0;
            return;
        end
        wrap = (m_presc == CPS - 1);
        case (m_mode)
            M_IDLE: begin
                if (e2) m_sel = (m_sel + 1) % 3;
                else if (e3) m_preset = bump(m_preset, m_sel);
                else if (e1 && m_preset != 0) begin m_mode = M_RUN; m_presc = 0; end
                m_work = m_preset;
            end
            M_RUN: begin
                m_presc = (m_presc + 1) % CPS;
                if (wrap) m_work = m_work - 1;
                if (wrap && m_work == 0) begin m_mode = M_DONE; m_acnt = 0; end
                else if (e1) m_mode = M_PAUSE;
            end
            M_PAUSE: begin
                if (e1) m_mode = M_RUN;
                else if (e2) begin m_mode = M_IDLE; m_work = m_preset; end
            end
            default: begin
                m_presc = (m_presc + 1) % CPS;
                if (wrap) m_acnt = m_acnt + 1;
                if (m_acnt == AS || e1 || e2 || e3) begin m_mode = M_IDLE; m_work = m_preset; end
            end
        endcase
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    initial forever begin
        logic [21:0] act, exp;
        @(negedge CLK);
        if (chk_en) begin
            exp = {disp(m_work), 2'(m_sel), 1'(m_mode == M_RUN), 1'(m_mode == M_DONE)};
            act = {tmr.HOUR, tmr.MINHIGH, tmr.MINLOW, tmr.SECHIGH, tmr.SECLOW, tmr.SEL,
                   tmr.RUNNING, tmr.ALARM};
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, act, exp);
            end
        end
    end

    function automatic logic [17:0] dig();
        return {tmr.HOUR, tmr.MINHIGH, tmr.MINLOW, tmr.SECHIGH, tmr.SECLOW};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            1: tmr.SW_F1 = v;
            2: tmr.SW_F2 = v;
            default: tmr.SW_F3 = v;
        endcase
    endtask

    // Press for one cycle then release for one cycle; returns one cycle after the sampling edge.
    task automatic press(input int b, input int times = 1);
        for (int i = 0; i < times; i++) begin
            set_btn(b, 1'b1);
            @(negedge CLK);
            set_btn(b, 1'b0);
            @(negedge CLK);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        tmr.TIMER_RUN = 1'b1;
        tmr.SW_F1 = 1'b0;
        tmr.SW_F2 = 1'b0;
        tmr.SW_F3 = 1'b0;
        @(negedge CLK);
        chk_en = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("reset_digits", 32'(dig()), 32'(disp(0)));
        check("reset_flags", {29'd0, tmr.SEL, tmr.ALARM}, 32'd0);

        // Set 0:01:05 and start
        press(2);
        check("sel_after_f2", 32'(tmr.SEL), 32'd1);
        press(3);
        check("minlow_inc", 32'(dig()), 32'(disp(hms(0, 1, 0))));
        press(2);
        press(3, 5);
        check("preset_0_01_05", 32'(dig()), 32'(disp(hms(0, 1, 5))));
        press(1);
        check("running_after_start", 32'(tmr.RUNNING), 32'd1);
        wait_cycles(3);
        check("first_tick", 32'(dig()), 32'(disp(hms(0, 1, 4))));
        wait_cycles(4);
        check("second_tick", 32'(dig()), 32'(disp(hms(0, 1, 3))));

        // Reset mid-count discards everything
        do_reset();
        check("rst_mid_digits", 32'(dig()), 32'(disp(0)));
        check("rst_mid_flags", {29'd0, tmr.SEL, tmr.RUNNING}, 32'd0);
        press(1);
        check("start_with_zero_preset", {30'd0, tmr.RUNNING, tmr.ALARM}, 32'd0);

        // Borrow across all fields, then field wraps in IDLE
        press(3);
        press(1);
        wait_cycles(3);
        check("borrow_1_00_00", 32'(dig()), 32'(disp(hms(0, 59, 59))));
        press(1);
        press(2);
        check("abort_restores", 32'(dig()), 32'(disp(hms(1, 0, 0))));
        press(2, 2);
        press(3, 59);
        check("sec_59", 32'(dig()), 32'(disp(hms(1, 0, 59))));
        press(3);
        check("sec_wrap_no_carry", 32'(dig()), 32'(disp(hms(1, 0, 0))));
        press(2);
        press(3, 8);
        check("hour_9", 32'(tmr.HOUR), 32'd9);
        press(3);
        check("hour_wrap", 32'(tmr.HOUR), 32'd0);

        // Expiry and auto-clear, then early clear by a button
        do_reset();
        press(2, 2);
        press(3, 2);
        press(1);
        wait_cycles(7);
        check("expiry_digits", 32'(dig()), 32'(disp(0)));
        check("expiry_flags", {30'd0, tmr.RUNNING, tmr.ALARM}, 32'd1);
        wait_cycles(7);
        check("alarm_still_high", 32'(tmr.ALARM), 32'd1);
        wait_cycles(1);
        check("alarm_auto_clear", 32'(tmr.ALARM), 32'd0);
        check("preset_after_clear", 32'(dig()), 32'(disp(hms(0, 0, 2))));
        press(1);
        wait_cycles(7);
        check("expiry_again", 32'(tmr.ALARM), 32'd1);
        press(3);
        check("alarm_ack", 32'(tmr.ALARM), 32'd0);
        check("ack_no_increment", 32'(dig()), 32'(disp(hms(0, 0, 2))));

        // Pause, resume, abort
        press(3, 7);
        check("preset_9", 32'(dig()), 32'(disp(hms(0, 0, 9))));
        press(1);
        wait_cycles(7);
        check("at_7", 32'(dig()), 32'(disp(hms(0, 0, 7))));
        press(1);
        check("paused_flag", 32'(tmr.RUNNING), 32'd0);
        wait_cycles(20);
        check("pause_holds", 32'(dig()), 32'(disp(hms(0, 0, 7))));
        press(1);
        check("resumed", 32'(tmr.RUNNING), 32'd1);
        wait_cycles(5);
        press(1);
        press(2);
        check("abort_digits", 32'(dig()), 32'(disp(hms(0, 0, 9))));
        check("abort_idle", {30'd0, tmr.RUNNING, tmr.ALARM}, 32'd0);

        // Held button and mode enable
        tmr.SW_F3 = 1'b1;
        wait_cycles(10);
        tmr.SW_F3 = 1'b0;
        wait_cycles(1);
        check("held_one_increment", 32'(dig()), 32'(disp(hms(0, 0, 10))));
        tmr.TIMER_RUN = 1'b0;
        press(1);
        check("disabled_start", 32'(tmr.RUNNING), 32'd0);
        tmr.TIMER_RUN = 1'b1;
        press(1);
        tmr.TIMER_RUN = 1'b0;
        press(1);
        wait_cycles(1);
        check("disabled_keeps_count", 32'(dig()), 32'(disp(hms(0, 0, 9))));
        check("disabled_still_running", 32'(tmr.RUNNING), 32'd1);
        tmr.TIMER_RUN = 1'b1;
        wait_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
